// File: rtl/fb_arb_pkg.sv
// Shared types and widths for the framebuffer memory arbiter.
package fb_arb_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 48;
  localparam int LEN_W  = 6;
  localparam int STAT_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_CMD  = 3'd1,
    RD_WAIT = 3'd2,
    WR_CMD  = 3'd3,
    WR_WAIT = 3'd4
  } state_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Single-clock show-ahead FIFO holding {addr,data} write words for the arbiter.
module fb_wr_fifo
  import fb_arb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = ADDR_W + DATA_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot in the same cycle, so a push against a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fb_arb.sv
// Framebuffer PSRAM arbiter: buffered serial-loader writes vs. video read bursts.
// Optional FB_ARB_STATS_EN adds wr_cnt/drop_cnt statistic outputs.
//
//  state   | meaning
//  IDLE    | no command outstanding, arbitrate next cycle
//  RD_CMD  | read burst command presented, waiting for mem_ready
//  RD_WAIT | read burst accepted, waiting for mem_done
//  WR_CMD  | FIFO head write presented, waiting for mem_ready
//  WR_WAIT | write accepted, waiting for mem_done
module fb_arb
  import fb_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_stb,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_ack,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LEN_W-1:0]  mem_len,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  output logic              ovf
`ifdef FB_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] wr_cnt,
  output logic [STAT_W-1:0] drop_cnt
`endif
);

  localparam int SC_W = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

  state_t                     state;
  state_t                     state_nxt;
  logic [SC_W-1:0]            starve_cnt;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       fifo_pop;
  logic [ADDR_W+DATA_W-1:0]   fifo_head;
  logic                       drop;
  logic                       rd_grant;
  logic                       wr_grant;
  logic                       valid_nxt;
  logic                       we_nxt;
  logic [ADDR_W-1:0]          addr_nxt;
  logic [LEN_W-1:0]           len_nxt;
  logic [DATA_W-1:0]          wdata_nxt;

  assign drop = wr_stb && fifo_full && !fifo_pop;

  fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (wr_stb),
    .din     ({wr_addr, wr_data}),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    rd_grant  = 1'b0;
    wr_grant  = 1'b0;
    rd_ack    = 1'b0;
    fifo_pop  = 1'b0;
    valid_nxt = mem_valid;
    we_nxt    = mem_we;
    addr_nxt  = mem_addr;
    len_nxt   = mem_len;
    wdata_nxt = mem_wdata;
    case (state)
      IDLE: begin
        // A full FIFO always wins so the loader stops losing words.
        if (rd_req && (fifo_empty || starve_cnt < STARVE_LIM) && !fifo_full) begin
          rd_grant  = 1'b1;
          state_nxt = RD_CMD;
          valid_nxt = 1'b1;
          we_nxt    = 1'b0;
          addr_nxt  = rd_addr;
          len_nxt   = rd_len;
        end else if (!fifo_empty) begin
          wr_grant  = 1'b1;
          state_nxt = WR_CMD;
          valid_nxt = 1'b1;
          we_nxt    = 1'b1;
          addr_nxt  = fifo_head[ADDR_W+DATA_W-1:DATA_W];
          len_nxt   = '0;
          wdata_nxt = fifo_head[DATA_W-1:0];
        end
      end
      RD_CMD: begin
        if (mem_ready) begin
          rd_ack    = 1'b1;
          valid_nxt = 1'b0;
          state_nxt = RD_WAIT;
        end
      end
      WR_CMD: begin
        if (mem_ready) begin
          fifo_pop  = 1'b1;
          valid_nxt = 1'b0;
          state_nxt = WR_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (mem_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_len   <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nxt;
      mem_valid <= valid_nxt;
      mem_we    <= we_nxt;
      mem_addr  <= addr_nxt;
      mem_len   <= len_nxt;
      mem_wdata <= wdata_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
      ovf        <= 1'b0;
    end else begin
      if (fifo_empty || wr_grant) starve_cnt <= '0;
      else if (rd_grant && starve_cnt != '1) starve_cnt <= starve_cnt + SC_W'(1);
      if (drop) ovf <= 1'b1;
    end
  end

`ifdef FB_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (state == WR_WAIT && mem_done) wr_cnt <= wr_cnt + STAT_W'(1);
      if (drop) drop_cnt <= drop_cnt + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fb_arb.sv
// Self-checking bench for fb_arb with a queue-based reference model of the write path.
module tb_fb_arb;
  import fb_arb_pkg::*;

  localparam int DEPTH = 8;
  localparam int SMAX  = 4;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              wr_stb = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [LEN_W-1:0]  rd_len = '0;
  logic              rd_ack;
  logic              mem_valid;
  logic              mem_ready = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LEN_W-1:0]  mem_len;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_done = 1'b0;
  logic              ovf;
`ifdef FB_ARB_STATS_EN
  logic [15:0]       wr_cnt;
  logic [15:0]       drop_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // memory responder controls (written by tests) and monitor records (written by monitor only)
  int   ready_mode = 0;
  int   done_delay = 1;
  int   rand_delay = 0;
  cmd_t cmds[$];
  int   ack_cnt = 0, ack_err = 0, overlap_err = 0, stab_err = 0, valid_cycles = 0;

  always #10 clk = ~clk;

  fb_arb #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_stb    (wr_stb),
    .wr_data   (wr_data),
    .wr_addr   (wr_addr),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_len    (rd_len),
    .rd_ack    (rd_ack),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_len   (mem_len),
    .mem_wdata (mem_wdata),
    .mem_done  (mem_done),
    .ovf       (ovf)
`ifdef FB_ARB_STATS_EN
    ,
    .wr_cnt    (wr_cnt),
    .drop_cnt  (drop_cnt)
`endif
  );

  // Memory model: drives ready/done at negedge+1, observes the command bus at negedge+2.
  always begin : mem_model
    int   pend;
    logic outstanding;
    logic prev_hold;
    cmd_t prev_cmd;
    cmd_t cur;
    pend = 0; outstanding = 1'b0; prev_hold = 1'b0; prev_cmd = '0;
    forever begin
      @(negedge clk);
      #1;
      mem_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) mem_done = 1'b1;
      end
      case (ready_mode)
        0:       mem_ready = 1'b0;
        1:       mem_ready = 1'b1;
        default: mem_ready = ($urandom_range(0, 1) == 1);
      endcase
      #1;
      cur = '{we: mem_we, addr: mem_addr, len: mem_len, wdata: mem_wdata};
      if (!reset_n) begin
        outstanding = 1'b0;
        prev_hold   = 1'b0;
      end else begin
        if (mem_valid) valid_cycles++;
        if (rd_ack) ack_cnt++;
        if (rd_ack !== (mem_valid && mem_ready && !mem_we)) ack_err++;
        if (mem_valid && outstanding) overlap_err++;
        if (prev_hold && (!mem_valid || cur !== prev_cmd)) stab_err++;
        prev_hold = mem_valid && !mem_ready;
        prev_cmd  = cur;
        if (mem_done) outstanding = 1'b0;
        if (mem_valid && mem_ready) begin
          outstanding = 1'b1;
          cmds.push_back(cur);
          pend = (rand_delay != 0) ? int'($urandom_range(1, 4)) : done_delay;
        end
      end
    end
  end

  task automatic idle_inputs();
    wr_stb = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0; rd_len = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    idle_inputs();
    ready_mode = 0; rand_delay = 0; done_delay = 1;
    repeat (8) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    int v0;
    @(negedge clk);
    reset_n = 1'b0; ready_mode = 1;
    wr_stb = 1'b1; wr_addr = 18'h3; wr_data = 48'hABCDEF;
    rd_req = 1'b1; rd_addr = 18'h7; rd_len = 6'd5;
    repeat (3) @(negedge clk);
    #3;
    n_cmp++;
    if ({mem_valid, mem_we, mem_addr, mem_len, mem_wdata, ovf, rd_ack} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got valid=%b we=%b addr=%h len=%h wdata=%h ovf=%b ack=%b, want all 0",
               mem_valid, mem_we, mem_addr, mem_len, mem_wdata, ovf, rd_ack);
    end
`ifdef FB_ARB_STATS_EN
    n_cmp++;
    if ({wr_cnt, drop_cnt} !== 32'h0) begin
      n_err++; $display("FAIL reset_stats: got wr_cnt=%0d drop_cnt=%0d, want 0/0", wr_cnt, drop_cnt);
    end
`endif
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b1;
    v0 = valid_cycles;
    repeat (5) @(negedge clk);
    #3;
    n_cmp++;
    if (valid_cycles - v0 !== 0 || mem_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_idle: got %0d valid cycles, want 0", valid_cycles - v0);
    end
  endtask

  task automatic test_writes();
    logic [DATA_W-1:0] exp_d [3];
    int b;
    do_reset();
    ready_mode = 1; done_delay = 2;
    b = cmds.size();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr_stb = 1'b1; wr_addr = ADDR_W'(i);
      wr_data = {16'($urandom()), 32'($urandom())};
      exp_d[i] = wr_data;
    end
    @(negedge clk);
    wr_stb = 1'b0;
    for (int c = 0; c < 60 && cmds.size() - b < 3; c++) @(negedge clk);
    repeat (4) @(negedge clk);
    #3;
    n_cmp++;
    if (cmds.size() - b !== 3) begin
      n_err++; $display("FAIL wr3_count: got %0d commands, want 3", cmds.size() - b);
    end
    for (int i = 0; i < 3 && b + i < cmds.size(); i++) begin
      n_cmp++;
      if (cmds[b+i] !== cmd_t'{we: 1'b1, addr: ADDR_W'(i), len: '0, wdata: exp_d[i]}) begin
        n_err++;
        $display("FAIL wr3_cmd%0d: got we=%b addr=%h len=%0d data=%h, want we=1 addr=%h len=0 data=%h",
                 i, cmds[b+i].we, cmds[b+i].addr, cmds[b+i].len, cmds[b+i].wdata, i, exp_d[i]);
      end
    end
    n_cmp++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL wr3_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_read();
    int b, a0, lat;
    logic ack_prev;
    do_reset();
    ready_mode = 1; done_delay = 3;
    b = cmds.size(); a0 = ack_cnt; lat = -1; ack_prev = 1'b0;
    @(negedge clk);
    rd_req = 1'b1; rd_addr = 18'h100; rd_len = 6'd39;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (ack_prev) rd_req = 1'b0;
      #3;
      if (mem_valid && lat < 0) lat = c;
      ack_prev = rd_ack;
    end
    n_cmp++;
    if (lat < 1 || lat > 2) begin n_err++; $display("FAIL rd_latency: got %0d cycles, want 1..2", lat); end
    n_cmp++;
    if (ack_cnt - a0 !== 1) begin n_err++; $display("FAIL rd_ack_pulses: got %0d, want 1", ack_cnt - a0); end
    n_cmp++;
    if (cmds.size() - b !== 1 || cmds[b] !== cmd_t'{we: 1'b0, addr: 18'h100, len: 6'd39, wdata: '0}) begin
      n_err++; $display("FAIL rd_cmd: got %0d commands (first we=%b addr=%h len=%0d), want 1 read 0x100 len 39",
                        cmds.size() - b, cmds[b].we, cmds[b].addr, cmds[b].len);
    end
  endtask

  task automatic test_starve();
    int b, reads_between, w_seen;
    do_reset();
    ready_mode = 0; done_delay = 1;
    b = cmds.size();
    @(negedge clk); wr_stb = 1'b1; wr_addr = 18'h0A; wr_data = 48'h1111;
    @(negedge clk); wr_stb = 1'b1; wr_addr = 18'h0B; wr_data = 48'h2222;
    @(negedge clk); wr_stb = 1'b0; rd_req = 1'b1; rd_addr = 18'h200; rd_len = 6'd7;
    @(negedge clk); ready_mode = 1;
    for (int c = 0; c < 100 && cmds.size() - b < 6; c++) @(negedge clk);
    rd_req = 1'b0;
    #3;
    reads_between = 0; w_seen = 0;
    for (int i = b; i < cmds.size() && w_seen < 2; i++) begin
      if (cmds[i].we) w_seen++;
      else if (w_seen == 1) reads_between++;
    end
    n_cmp++;
    if (cmds.size() - b < 6 || cmds[b].we !== 1'b1 || cmds[b].addr !== 18'h0A) begin
      n_err++; $display("FAIL starve_first: got %0d cmds, first we=%b addr=%h, want write to 0x0A",
                        cmds.size() - b, cmds[b].we, cmds[b].addr);
    end
    n_cmp++;
    if (reads_between !== SMAX || w_seen !== 2) begin
      n_err++; $display("FAIL starve_reads: got %0d reads between writes (writes=%0d), want %0d",
                        reads_between, w_seen, SMAX);
    end
    n_cmp++;
    if (cmds.size() - b >= 6 && cmds[b+5] !== cmd_t'{we: 1'b1, addr: 18'h0B, len: '0, wdata: 48'h2222}) begin
      n_err++; $display("FAIL starve_wr2: got we=%b addr=%h, want write 0x0B", cmds[b+5].we, cmds[b+5].addr);
    end
  endtask

  // fill with ready low; extra_pop=1 pushes word 9 in the cycle of the first pop
  task automatic test_overflow(input bit extra_pop);
    logic [ADDR_W+DATA_W-1:0] exp_w [9];
    int b, n_exp;
    do_reset();
    ready_mode = 0; done_delay = 1;
    b = cmds.size();
    for (int i = 0; i < 9; i++) exp_w[i] = {ADDR_W'(18'h1000 + i), 16'($urandom()), 32'($urandom())};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 8 && extra_pop) ready_mode = 1;
      wr_stb = 1'b1;
      {wr_addr, wr_data} = exp_w[i];
      #3;
      if (i == 8) begin
        n_cmp++;
        if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_after8: got %b want 0", ovf); end
      end
    end
    @(negedge clk);
    wr_stb = 1'b0;
    #3;
    n_exp = extra_pop ? 9 : 8;
    n_cmp++;
    if (ovf !== !extra_pop) begin
      n_err++; $display("FAIL ovf_after9(pop=%0d): got %b want %b", extra_pop, ovf, !extra_pop);
    end
    ready_mode = 1;
    for (int c = 0; c < 150 && cmds.size() - b < n_exp; c++) @(negedge clk);
    repeat (10) @(negedge clk);
    #3;
    n_cmp++;
    if (cmds.size() - b !== n_exp) begin
      n_err++; $display("FAIL full_writes(pop=%0d): got %0d writes want %0d", extra_pop, cmds.size() - b, n_exp);
    end
    for (int i = 0; i < n_exp && b + i < cmds.size(); i++) begin
      n_cmp++;
      if (!cmds[b+i].we || {cmds[b+i].addr, cmds[b+i].wdata} !== exp_w[i] || cmds[b+i].len !== '0) begin
        n_err++; $display("FAIL full_wr%0d: got we=%b addr=%h data=%h, want addr=%h data=%h", i,
                          cmds[b+i].we, cmds[b+i].addr, cmds[b+i].wdata,
                          exp_w[i][ADDR_W+DATA_W-1:DATA_W], exp_w[i][DATA_W-1:0]);
      end
    end
`ifdef FB_ARB_STATS_EN
    n_cmp++;
    if (wr_cnt !== 16'(n_exp) || drop_cnt !== 16'(!extra_pop)) begin
      n_err++; $display("FAIL stats(pop=%0d): got wr_cnt=%0d drop_cnt=%0d want %0d/%0d",
                        extra_pop, wr_cnt, drop_cnt, n_exp, !extra_pop);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int b, v0;
    do_reset();
    ready_mode = 1; done_delay = 6;
    b = cmds.size();
    @(negedge clk); wr_stb = 1'b1; wr_addr = 18'h2AAAA; wr_data = 48'h5A5A_1234_5678;
    @(negedge clk); wr_stb = 1'b1; wr_addr = 18'h15555; wr_data = 48'hA5A5_8765_4321;
    @(negedge clk); wr_stb = 1'b0;
    for (int c = 0; c < 20 && cmds.size() - b < 1; c++) @(negedge clk);
    @(negedge clk);
    #5;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_valid, mem_we, mem_addr, mem_len, mem_wdata, ovf, rd_ack} !== '0) begin
      n_err++; $display("FAIL async_reset: got valid=%b we=%b addr=%h len=%h wdata=%h, want all 0",
                        mem_valid, mem_we, mem_addr, mem_len, mem_wdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    b = cmds.size(); v0 = valid_cycles;
    repeat (20) @(negedge clk);
    #3;
    n_cmp++;
    if (cmds.size() - b !== 0 || valid_cycles - v0 !== 0) begin
      n_err++; $display("FAIL post_reset_idle: got %0d cmds, %0d valid cycles, want 0/0",
                        cmds.size() - b, valid_cycles - v0);
    end
  endtask

  task automatic test_random();
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    int   pops, drops, reads, consec, max_consec, a0, ae0, oe0, se0;
    logic model_ovf, ack_seen, hs_w, hs_r;
    do_reset();
    ready_mode = 2; rand_delay = 1;
    pops = 0; drops = 0; reads = 0; consec = 0; max_consec = 0;
    model_ovf = 1'b0; ack_seen = 1'b0;
    a0 = ack_cnt; ae0 = ack_err; oe0 = overlap_err; se0 = stab_err;
    for (int c = 0; c < 1800; c++) begin
      @(negedge clk);
      if (ack_seen) rd_req = 1'b0;
      else if (c < 1500 && !rd_req && $urandom_range(0, 99) < 20) begin
        rd_req = 1'b1; rd_addr = ADDR_W'($urandom()); rd_len = LEN_W'($urandom());
      end
      wr_stb  = (c < 1500) && ($urandom_range(0, 99) < 45);
      wr_addr = ADDR_W'($urandom());
      wr_data = {16'($urandom()), 32'($urandom())};
      #3;
      hs_w = mem_valid && mem_ready && mem_we;
      hs_r = mem_valid && mem_ready && !mem_we;
      if (exp_q.size() == 0) consec = 0;
      if (hs_w) begin
        n_cmp++;
        if (exp_q.size() == 0 || {mem_addr, mem_wdata} !== exp_q[0] || mem_len !== '0) begin
          n_err++; $display("FAIL rand_write c=%0d: got addr=%h data=%h len=%0d, want head of %0d-entry model",
                            c, mem_addr, mem_wdata, mem_len, exp_q.size());
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        pops++;
        consec = 0;
      end
      if (hs_r) begin
        reads++;
        n_cmp++;
        if (!rd_req || mem_addr !== rd_addr || mem_len !== rd_len) begin
          n_err++; $display("FAIL rand_read c=%0d: got addr=%h len=%0d, want %h/%0d", c, mem_addr, mem_len, rd_addr, rd_len);
        end
        if (exp_q.size() > 0) consec++;
        if (consec > max_consec) max_consec = consec;
      end
      if (wr_stb) begin
        if (exp_q.size() < DEPTH) exp_q.push_back({wr_addr, wr_data});
        else begin model_ovf = 1'b1; drops++; end
      end
      ack_seen = rd_ack;
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin n_err++; $display("FAIL rand_drain: got %0d words left, want 0", exp_q.size()); end
    n_cmp++;
    if (ovf !== model_ovf) begin n_err++; $display("FAIL rand_ovf: got %b want %b (drops=%0d)", ovf, model_ovf, drops); end
    n_cmp++;
    if (ack_cnt - a0 !== reads) begin n_err++; $display("FAIL rand_acks: got %0d want %0d", ack_cnt - a0, reads); end
    n_cmp++;
    if (ack_err - ae0 !== 0 || overlap_err - oe0 !== 0 || stab_err - se0 !== 0) begin
      n_err++; $display("FAIL rand_protocol: got ack_err=%0d overlap=%0d unstable=%0d, want 0",
                        ack_err - ae0, overlap_err - oe0, stab_err - se0);
    end
    // one grant may be made while the FIFO is still empty, before words arrive
    n_cmp++;
    if (max_consec > SMAX + 1) begin
      n_err++; $display("FAIL rand_starve: got %0d consecutive reads with pending writes, want <= %0d", max_consec, SMAX + 1);
    end
`ifdef FB_ARB_STATS_EN
    n_cmp++;
    if (wr_cnt !== 16'(pops) || drop_cnt !== 16'(drops)) begin
      n_err++; $display("FAIL rand_stats: got wr_cnt=%0d drop_cnt=%0d want %0d/%0d", wr_cnt, drop_cnt, pops, drops);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_writes();
    test_read();
    test_starve();
    test_overflow(1'b0);
    test_overflow(1'b1);
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
